map_sst_seq: RTL and testbench
==============================

# map_sst_seq

Save-state sequencer for the mapper register file. On request, it walks mapper save-state addresses 0..REG_NUM-1 and moves each byte between the mapper and an external save-state buffer memory. It sits between the system save-state engine and the mapper's `sst` port, and owns `sst.act` for the whole transfer. Mapper register writes from the CPU are therefore locked out until the transfer completes.

## Interface
Parameters:
- REG_NUM, 9, number of mapper save-state registers (8 bank regs + ctrl); legal 1..255
- ACK_TMO, 255, max cycles to wait for `buf_ack` before abort; legal 1..255

Ports:
- clk  in  1  system clock; all logic on posedge
- map_rst_n  in  1  reset, asynchronous assert, active-low; clears all state and outputs
- save_req  in  1  start save (mapper -> buffer); sampled in IDLE only
- load_req  in  1  start load (buffer -> mapper); sampled in IDLE only
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of transfer, successful or aborted
- err  out  1  sticky: last transfer aborted on timeout
- sst_act  out  1  save-state active; mapper ignores CPU register writes while high
- sst_addr  out  8  mapper save-state register index
- sst_we_map  out  1  one-cycle mapper register write strobe
- sst_dato  out  8  data to mapper
- sst_di  in  8  mapper readback for `sst_addr` (combinational in mapper)
- buf_addr  out  8  buffer byte address (= register index)
- buf_dout  out  8  buffer write data
- buf_we  out  1  buffer write request; held until ack
- buf_re  out  1  buffer read request; held until ack
- buf_din  in  8  buffer read data, valid when `buf_ack`=1
- buf_ack  in  1  buffer completion; may be high in the same cycle as the request

## Operation
- Reset values: every output is 0; state is IDLE; index is 0; timer is 0.
- States:
  - IDLE, SV_RD, SV_WR, LD_RQ, LD_WR, FIN.
- IDLE:
  - `save_req` -> SV_RD.
  - else `load_req` -> LD_RQ.
  - If both are high, save wins.
  - Accepting a request clears `err` and index.
- SV_RD:
  - `sst_act`=1, `sst_addr`=index.
  - Registers `sst_di` into the data latch.
  - -> SV_WR.
- SV_WR:
  - `buf_we`=1, `buf_addr`=index, `buf_dout`=latch.
  - On `buf_ack`: if index==REG_NUM-1 -> FIN, else index+1 -> SV_RD.
- LD_RQ:
  - `sst_act`=1, `buf_re`=1, `buf_addr`=index.
  - On `buf_ack`: latch `buf_din` -> LD_WR.
- LD_WR:
  - `sst_we_map`=1, `sst_addr`=index, `sst_dato`=latch.
  - If last index -> FIN, else index+1 -> LD_RQ.
- FIN:
  - `done`=1; `sst_act`=0; `busy`=1.
  - -> IDLE.
- `busy`=1 in every state except IDLE.
- `sst_act`=1 in SV_RD, SV_WR, LD_RQ, LD_WR.
- Requests arriving while busy are ignored (not queued).
- Timeout:
  - The timer counts cycles spent in SV_WR or LD_RQ without `buf_ack`.
  - It resets on every state entry.
  - When it reaches ACK_TMO: drop the request, set `err`=1, -> FIN.
- `sst_addr`, `buf_addr` and `sst_dato` are held stable while their strobe or request is high.
- The index is 8-bit and never wraps; the final index is REG_NUM-1.
- Reset mid-transfer: `sst_act`, strobes and `busy` go to 0 immediately (async). No done pulse is issued. Mapper registers keep whatever was already written.

## Timing
- All outputs are registered, or are decoded from registered state and index only. There is no combinational input-to-output path.
- Request high at edge t -> `busy`/`sst_act` high from t+1.
- Save, zero-wait ack: 2 cycles per register; `done` at cycle t+1+2·REG_NUM. For REG_NUM=9, `done` is 19 cycles after accept.
- Load, zero-wait ack: 2 cycles per register; same total.
- Each wait cycle on `buf_ack` adds exactly 1 cycle.
- `sst_di` is sampled one cycle after `sst_addr` becomes valid, so the mapper decode has a full cycle to settle.
- Back-to-back: a new request can be accepted on the cycle after FIN (first IDLE cycle).

## Structure
- Package `map_sst_pkg`:
  - state enum `sst_seq_st_t`
  - width constants `SST_AW`=8, `SST_DW`=8
  - default REG_NUM
- Sub-module `map_sst_tmo`:
  - ack timeout counter
  - inputs: clk, map_rst_n, clr, run
  - output: expired
  - parameter ACK_TMO

## Test plan
- Save, REG_NUM=9, mapper regs = 0..7 plus ctrl=0x5, `buf_ack` tied high -> buffer bytes 0..8 = 00,01,..,07,05; `done` exactly 19 cycles after accept; `sst_we_map` never high.
- Load, buffer = 1F,1E,..,18,07, ack high -> 9 `sst_we_map` pulses with matching addr/data; `sst_act` high for 18 cycles; mapper ctrl=7.
- Save with 3-cycle ack latency per byte -> total 1+9·(1+4)=46 cycles to `done`; `buf_dout`/`buf_addr` stable while `buf_we` high.
- `save_req` and `load_req` high together in IDLE -> save executes; a `load_req` during busy is ignored, and `done` pulses once.
- `buf_ack` held low during load, ACK_TMO=16 -> after 16 cycles in LD_RQ: `err`=1, `done` pulse, no `sst_we_map`; the next accepted request clears `err`.
- `map_rst_n` low mid-save at index 4 -> all outputs 0 asynchronously; after release, IDLE; a fresh save completes normally from index 0.

Source files
------------

// File: rtl/map_sst_pkg.sv
// rtl/map_sst_pkg.sv - shared types and constants for the mapper save-state sequencer
// Purpose: state encoding, bus widths and default parameters used by map_sst_seq and map_sst_tmo.
// Ports: none (package).
package map_sst_pkg;

   localparam int SST_AW      = 8;    // save-state / buffer address width
   localparam int SST_DW      = 8;    // save-state / buffer data width
   localparam int REG_NUM_DEF = 9;    // 8 bank registers + ctrl
   localparam int ACK_TMO_DEF = 255;  // cycles to wait for buf_ack before abort

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SV_RD,
      ST_SV_WR,
      ST_LD_RQ,
      ST_LD_WR,
      ST_FIN
   } sst_seq_st_t;

endpackage

// File: rtl/map_sst_tmo.sv
// rtl/map_sst_tmo.sv - buffer acknowledge timeout counter
// Purpose: counts cycles spent waiting for buf_ack and flags expiry on the ACK_TMO-th one.
// Ports:
//   clk, map_rst_n : clock, async active-low reset
//   clr            : hold the count at zero (sequencer not in a wait state)
//   run            : waiting this cycle (wait state and no ack)
//   expired        : this is the ACK_TMO-th consecutive wait cycle
module map_sst_tmo
   import map_sst_pkg::*;
#(
   parameter int ACK_TMO = ACK_TMO_DEF
) (
   input  logic clk,
   input  logic map_rst_n,
   input  logic clr,
   input  logic run,
   output logic expired
);

   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n) begin
         cnt_q <= 8'd0;
      end else if (clr) begin
         cnt_q <= 8'd0;
      end else if (run) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   // Flag on the cycle whose increment would reach ACK_TMO, so the sequencer
   // leaves the wait state at that same edge.
   assign expired = run && (cnt_q == 8'(ACK_TMO - 1));

endmodule

// File: rtl/map_sst_seq.sv
// rtl/map_sst_seq.sv - mapper save-state sequencer between save-state engine, mapper and buffer memory
// Purpose: on save_req copies mapper registers 0..REG_NUM-1 into the buffer; on load_req copies
//   buffer bytes back into the mapper. Owns sst_act for the whole transfer.
// Ports:
//   clk, map_rst_n           : clock, async active-low reset
//   save_req, load_req       : start requests, sampled in IDLE only (save wins)
//   busy, done, err          : status; done pulses in FIN, err sticky until next accept
//   sst_act, sst_addr        : mapper save-state port control
//   sst_we_map, sst_dato     : mapper write strobe/data
//   sst_di                   : mapper readback for sst_addr
//   buf_addr, buf_dout       : buffer address / write data
//   buf_we, buf_re           : buffer requests, held until buf_ack
//   buf_din, buf_ack         : buffer read data / completion
module map_sst_seq
   import map_sst_pkg::*;
#(
   parameter int REG_NUM = REG_NUM_DEF,
   parameter int ACK_TMO = ACK_TMO_DEF
) (
   input  logic              clk,
   input  logic              map_rst_n,
   input  logic              save_req,
   input  logic              load_req,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              sst_act,
   output logic [SST_AW-1:0] sst_addr,
   output logic              sst_we_map,
   output logic [SST_DW-1:0] sst_dato,
   input  logic [SST_DW-1:0] sst_di,
   output logic [SST_AW-1:0] buf_addr,
   output logic [SST_DW-1:0] buf_dout,
   output logic              buf_we,
   output logic              buf_re,
   input  logic [SST_DW-1:0] buf_din,
   input  logic              buf_ack
);

   sst_seq_st_t       state_q;
   logic [SST_AW-1:0] idx_q;
   logic [SST_DW-1:0] lat_q;
   logic              err_q;

   logic in_wait;
   logic is_last;
   logic tmo_exp;

   // Only SV_WR and LD_RQ wait on buf_ack; every other state holds the timer at
   // zero, so it restarts on each entry into a wait state.
   assign in_wait = (state_q == ST_SV_WR) || (state_q == ST_LD_RQ);
   assign is_last = (idx_q == SST_AW'(REG_NUM - 1));

   map_sst_tmo #(
      .ACK_TMO (ACK_TMO)
   ) u_tmo (
      .clk       (clk),
      .map_rst_n (map_rst_n),
      .clr       (!in_wait),
      .run       (in_wait && !buf_ack),
      .expired   (tmo_exp)
   );

   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         lat_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (save_req) begin
                  state_q <= ST_SV_RD;
                  idx_q   <= '0;
                  err_q   <= 1'b0;
               end else if (load_req) begin
                  state_q <= ST_LD_RQ;
                  idx_q   <= '0;
                  err_q   <= 1'b0;
               end
            end
            ST_SV_RD: begin
               // sst_addr has been stable for this whole cycle, so the mapper
               // readback has settled by this edge.
               lat_q   <= sst_di;
               state_q <= ST_SV_WR;
            end
            ST_SV_WR: begin
               if (buf_ack) begin
                  if (is_last) begin
                     state_q <= ST_FIN;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= ST_SV_RD;
                  end
               end else if (tmo_exp) begin
                  err_q   <= 1'b1;
                  state_q <= ST_FIN;
               end
            end
            ST_LD_RQ: begin
               if (buf_ack) begin
                  lat_q   <= buf_din;
                  state_q <= ST_LD_WR;
               end else if (tmo_exp) begin
                  err_q   <= 1'b1;
                  state_q <= ST_FIN;
               end
            end
            ST_LD_WR: begin
               if (is_last) begin
                  state_q <= ST_FIN;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= ST_LD_RQ;
               end
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from registered state only; an async reset of
   // state_q drops every strobe and request at once.
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FIN);
   assign err        = err_q;
   assign sst_act    = (state_q == ST_SV_RD) || (state_q == ST_SV_WR) ||
                       (state_q == ST_LD_RQ) || (state_q == ST_LD_WR);
   assign sst_we_map = (state_q == ST_LD_WR);
   assign buf_we     = (state_q == ST_SV_WR);
   assign buf_re     = (state_q == ST_LD_RQ);
   assign sst_addr   = sst_act ? idx_q : '0;
   assign sst_dato   = sst_we_map ? lat_q : '0;
   assign buf_addr   = (buf_we || buf_re) ? idx_q : '0;
   assign buf_dout   = buf_we ? lat_q : '0;

endmodule

// File: tb/tb_map_sst_seq.sv
// tb/tb_map_sst_seq.sv - scoreboard bench for map_sst_seq
module tb_map_sst_seq;

   localparam int N   = 9;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       map_rst_n;
   logic       save_req, load_req;
   logic       busy, done, err, sst_act, sst_we_map, buf_we, buf_re, buf_ack;
   logic [7:0] sst_addr, sst_dato, sst_di, buf_addr, buf_dout, buf_din;

   always #5 clk = ~clk;

   map_sst_seq #(.REG_NUM(N), .ACK_TMO(TMO)) dut (
      .clk        (clk),
      .map_rst_n  (map_rst_n),
      .save_req   (save_req),
      .load_req   (load_req),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .sst_act    (sst_act),
      .sst_addr   (sst_addr),
      .sst_we_map (sst_we_map),
      .sst_dato   (sst_dato),
      .sst_di     (sst_di),
      .buf_addr   (buf_addr),
      .buf_dout   (buf_dout),
      .buf_we     (buf_we),
      .buf_re     (buf_re),
      .buf_din    (buf_din),
      .buf_ack    (buf_ack)
   );

   // mapper register file and buffer memory models
   logic [7:0] map_regs [256];
   logic [7:0] mem [256];
   int         lat_cfg = 0;
   bit         ack_en  = 1'b1;
   int         wcnt    = 0;

   always_comb sst_di  = map_regs[sst_addr];
   always_comb buf_din = mem[buf_addr];
   always_comb buf_ack = ack_en && (buf_we || buf_re) && (wcnt >= lat_cfg);

   always @(posedge clk) begin
      if ((buf_we || buf_re) && !buf_ack) wcnt <= wcnt + 1;
      else                                wcnt <= 0;
      if (sst_we_map)        map_regs[sst_addr] = sst_dato;
      if (buf_we && buf_ack) mem[buf_addr] = buf_dout;
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got unexpected event 0x%0h expected none", nm, act);
   endtask

   // scoreboard
   typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
   typedef struct packed { logic err; logic [31:0] dly; } dn_t;
   wr_t exp_buf_q[$];
   wr_t exp_map_q[$];
   dn_t exp_done_q[$];

   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         acc_cyc = 0, act_cnt = 0;
   logic       prev_busy, prev_we, prev_re, prev_ack;
   logic [7:0] prev_baddr, prev_bdout;
   wr_t        m_w;
   dn_t        m_d;

   always @(negedge clk) begin
      if (!map_rst_n) begin
         prev_busy = 1'b0; prev_we = 1'b0; prev_re = 1'b0; prev_ack = 1'b0;
         prev_baddr = 8'h00; prev_bdout = 8'h00;
      end else begin
         if (busy && !prev_busy) begin
            acc_cyc = cyc;
            act_cnt = 0;
         end
         if (sst_act) act_cnt++;
         if (buf_we && buf_ack) begin
            if (exp_buf_q.size() == 0) unexp("buf_write", {buf_addr, buf_dout});
            else begin
               m_w = exp_buf_q.pop_front();
               chk("buf_wr_addr", buf_addr, m_w.addr);
               chk("buf_wr_data", buf_dout, m_w.data);
            end
         end
         if (sst_we_map) begin
            if (exp_map_q.size() == 0) unexp("map_write", {sst_addr, sst_dato});
            else begin
               m_w = exp_map_q.pop_front();
               chk("map_wr_addr", sst_addr, m_w.addr);
               chk("map_wr_data", sst_dato, m_w.data);
            end
         end
         if (done) begin
            if (exp_done_q.size() == 0) unexp("done", 64'(cyc - acc_cyc));
            else begin
               m_d = exp_done_q.pop_front();
               chk("done_err", err, m_d.err);
               chk("done_delay", 64'(cyc - acc_cyc), m_d.dly);
               chk("act_cycles", 64'(act_cnt), m_d.dly);
            end
         end
         if (((buf_we && prev_we) || (buf_re && prev_re)) && !prev_ack) begin
            chk("buf_addr_stable", buf_addr, prev_baddr);
            if (buf_we) chk("buf_dout_stable", buf_dout, prev_bdout);
         end
         prev_busy = busy; prev_we = buf_we; prev_re = buf_re; prev_ack = buf_ack;
         prev_baddr = buf_addr; prev_bdout = buf_dout;
      end
   end

   task automatic wait_idle(input string nm);
      int k = 0;
      while (busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (busy) unexp({nm, "_timeout"}, 64'(k));
   endtask

   // Called at a negedge with the DUT idle. Expected transfer: N byte moves,
   // each taking lat+2 cycles, done after N*(lat+2) edges past the accept edge.
   task automatic do_xfer(input bit is_save, input int lat, input bit both, input bit poke_load);
      lat_cfg = lat;
      ack_en  = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (is_save) exp_buf_q.push_back({8'(i), map_regs[i]});
         else         exp_map_q.push_back({8'(i), mem[i]});
      end
      exp_done_q.push_back({1'b0, 32'(N * (lat + 2))});
      save_req = is_save;
      load_req = !is_save || both;
      @(negedge clk);
      save_req = 1'b0;
      load_req = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("act_after_accept", sst_act, 1);
      chk("err_clear_on_accept", err, 0);
      if (poke_load) begin
         load_req = 1'b1;
         repeat (3) @(negedge clk);
         load_req = 1'b0;
      end
      wait_idle("xfer");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      map_rst_n = 1'b0;
      save_req  = 1'b0;
      load_req  = 1'b0;
      for (int i = 0; i < 256; i++) begin
         map_regs[i] = 8'h00;
         mem[i]      = 8'h00;
      end
      #1;
      chk("reset_outputs", {busy, done, err, sst_act, sst_we_map, buf_we, buf_re,
                            sst_addr, sst_dato, buf_addr, buf_dout}, 0);
      repeat (3) @(negedge clk);
      map_rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", busy, 0);

      // save of known mapper contents, zero-wait ack
      for (int i = 0; i < 8; i++) map_regs[i] = 8'(i);
      map_regs[8] = 8'h05;
      do_xfer(1'b1, 0, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) chk("save_buf_byte", mem[i], (i < 8) ? 64'(i) : 64'h5);

      // load of known buffer contents, zero-wait ack (back-to-back)
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'h1F - i);
      mem[8] = 8'h07;
      do_xfer(1'b0, 0, 1'b0, 1'b0);
      chk("map_ctrl_after_load", map_regs[8], 8'h07);
      chk("map_reg0_after_load", map_regs[0], 8'h1F);

      // save with 3 wait cycles per byte
      for (int i = 0; i < N; i++) map_regs[i] = 8'($urandom);
      do_xfer(1'b1, 3, 1'b0, 1'b0);

      // both requests together, plus a load_req while busy
      for (int i = 0; i < N; i++) map_regs[i] = 8'($urandom);
      do_xfer(1'b1, 0, 1'b1, 1'b1);

      // load with buf_ack held low: timeout abort
      ack_en = 1'b0;
      exp_done_q.push_back({1'b1, 32'(TMO)});
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      wait_idle("timeout");
      repeat (2) @(negedge clk);
      chk("err_sticky", err, 1);
      ack_en = 1'b1;

      // next accepted request clears err
      for (int i = 0; i < N; i++) map_regs[i] = 8'($urandom);
      do_xfer(1'b1, 1, 1'b0, 1'b0);

      // async reset mid-save at index 4
      lat_cfg = 0;
      for (int i = 0; i < N; i++) map_regs[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) exp_buf_q.push_back({8'(i), map_regs[i]});
      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      begin
         int k = 0;
         while (!(sst_act && sst_addr == 8'd4) && k < 100) begin
            @(negedge clk);
            k++;
         end
         if (k >= 100) unexp("reach_index4_timeout", 64'(k));
      end
      #2 map_rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {busy, done, err, sst_act, sst_we_map, buf_we, buf_re,
                                  sst_addr, sst_dato, buf_addr, buf_dout}, 0);
      repeat (2) @(negedge clk);
      map_rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_mid_reset", busy, 0);
      chk("mid_reset_writes_drained", 64'(exp_buf_q.size()), 0);
      chk("mid_reset_no_done", 64'(exp_done_q.size()), 0);
      do_xfer(1'b1, 0, 1'b0, 1'b0);

      // randomized transfers
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < N; i++) begin
            map_regs[i] = 8'($urandom);
            mem[i]      = 8'($urandom);
         end
         do_xfer(1'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("buf_q_empty", 64'(exp_buf_q.size()), 0);
      chk("map_q_empty", 64'(exp_map_q.size()), 0);
      chk("done_q_empty", 64'(exp_done_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
